// File: rtl/ddr3_axi_rd_arbiter_if.sv
// ddr3_axi_rd_arbiter_if: requester command/data ports and AXI4 AR/R channel of the read arbiter
interface ddr3_axi_rd_arbiter_if #(parameter int C_ID_WIDTH = 2);
  logic                  phy_init_done;
  logic                  req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0]           req0_addr, req1_addr;
  logic [7:0]            req0_len, req1_len;
  logic [31:0]           rd0_data, rd1_data;
  logic                  rd0_valid, rd0_last, rd0_ready, rd1_valid, rd1_last, rd1_ready;
  logic [C_ID_WIDTH-1:0] m_axi_arid, m_axi_rid;
  logic [31:0]           m_axi_araddr, m_axi_rdata;
  logic [7:0]            m_axi_arlen;
  logic [2:0]            m_axi_arsize;
  logic [1:0]            m_axi_arburst, m_axi_rresp;
  logic                  m_axi_arvalid, m_axi_arready, m_axi_rlast, m_axi_rvalid, m_axi_rready;
  logic                  err_pulse, busy;
  modport master (
    input  phy_init_done, req0_valid, req0_addr, req0_len, rd0_ready,
           req1_valid, req1_addr, req1_len, rd1_ready,
           m_axi_arready, m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    output req0_ready, rd0_data, rd0_valid, rd0_last, req1_ready, rd1_data, rd1_valid, rd1_last,
           m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
           m_axi_rready, err_pulse, busy
  );
  modport slave (
    output phy_init_done, req0_valid, req0_addr, req0_len, rd0_ready,
           req1_valid, req1_addr, req1_len, rd1_ready,
           m_axi_arready, m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    input  req0_ready, rd0_data, rd0_valid, rd0_last, req1_ready, rd1_data, rd1_valid, rd1_last,
           m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
           m_axi_rready, err_pulse, busy
  );
endinterface

// File: rtl/ddr3_axi_rd_arbiter.sv
// ddr3_axi_rd_arbiter: round-robin two-requester burst-read sequencer onto one AXI4 AR/R channel
module ddr3_axi_rd_arbiter #(
  parameter logic [31:0] C_BASEADDR = 32'hA4000000,
  parameter logic [31:0] C_HIGHADDR = 32'hA7FFFFFF,
  parameter int          C_ID_WIDTH = 2
) (
  input logic clk,
  input logic rst,
  ddr3_axi_rd_arbiter_if.master bus
);
  typedef enum logic [1:0] {WAIT_INIT, IDLE, ADDR, DATA} state_t;
  state_t      state, nxt;
  logic        last_g, g_q, rej_q;
  logic [31:0] addr_q;
  logic [7:0]  len_q, cnt;
  logic        pick, grant, legal, in_data, beat, cnt_zero, fin, beat_err;
  logic [31:0] sel_addr;
  logic [7:0]  sel_len;
  logic [32:0] end_addr;
  always_comb begin
    pick     = (bus.req0_valid & bus.req1_valid) ? ~last_g : bus.req1_valid;
    grant    = (state == IDLE) & (bus.req0_valid | bus.req1_valid);
    sel_addr = pick ? bus.req1_addr : bus.req0_addr;
    sel_len  = pick ? bus.req1_len : bus.req0_len;
    end_addr = {1'b0, sel_addr} + {23'b0, sel_len, 2'b00} + 33'd3;
    legal    = (sel_addr >= C_BASEADDR) && (end_addr <= {1'b0, C_HIGHADDR}) && (sel_addr[1:0] == 2'b00);
    in_data  = state == DATA;
    beat     = in_data & bus.m_axi_rvalid & bus.m_axi_rready;
    cnt_zero = cnt == 8'd0;
    fin      = beat & (bus.m_axi_rlast | cnt_zero);
    // burst length disagreement is flagged in either direction; the beat still passes through
    beat_err = beat & ((bus.m_axi_rresp != 2'b00) | (bus.m_axi_rlast != cnt_zero));
    nxt      = state;
    unique case (state)
      WAIT_INIT: nxt = bus.phy_init_done ? IDLE : WAIT_INIT;
      IDLE:      nxt = (grant & legal) ? ADDR : IDLE;
      ADDR:      nxt = bus.m_axi_arready ? DATA : ADDR;
      DATA:      nxt = fin ? IDLE : DATA;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) state <= WAIT_INIT;
    else state <= nxt;
  always_ff @(posedge clk)
    if (rst) begin
      last_g <= 1'b1;
      g_q    <= 1'b0;
      rej_q  <= 1'b0;
      addr_q <= '0;
      len_q  <= '0;
      cnt    <= '0;
    end else begin
      rej_q <= grant & ~legal;
      if (grant) begin
        last_g <= pick;
        g_q    <= pick;
        addr_q <= sel_addr;
        len_q  <= sel_len;
      end
      if (state == ADDR && bus.m_axi_arready) cnt <= len_q;
      else if (beat) cnt <= cnt - 8'd1;
    end
  assign bus.req0_ready    = grant & ~pick;
  assign bus.req1_ready    = grant & pick;
  assign bus.m_axi_arvalid = state == ADDR;
  assign bus.m_axi_araddr  = bus.m_axi_arvalid ? addr_q : '0;
  assign bus.m_axi_arlen   = bus.m_axi_arvalid ? len_q : '0;
  assign bus.m_axi_arid    = bus.m_axi_arvalid ? C_ID_WIDTH'(g_q) : '0;
  assign bus.m_axi_arsize  = 3'b010;
  assign bus.m_axi_arburst = 2'b01;
  assign bus.m_axi_rready  = in_data & (g_q ? bus.rd1_ready : bus.rd0_ready);
  assign bus.rd0_valid     = in_data & ~g_q & bus.m_axi_rvalid;
  assign bus.rd1_valid     = in_data & g_q & bus.m_axi_rvalid;
  assign bus.rd0_data      = (in_data & ~g_q) ? bus.m_axi_rdata : '0;
  assign bus.rd1_data      = (in_data & g_q) ? bus.m_axi_rdata : '0;
  assign bus.rd0_last      = bus.rd0_valid & (bus.m_axi_rlast | cnt_zero);
  assign bus.rd1_last      = bus.rd1_valid & (bus.m_axi_rlast | cnt_zero);
  assign bus.err_pulse     = rej_q | beat_err;
  assign bus.busy          = (state == ADDR) | in_data;
endmodule

// File: tb/tb_ddr3_axi_rd_arbiter.sv
// tb_ddr3_axi_rd_arbiter: directed self-checking bench for the two-requester AXI read arbiter
module tb_ddr3_axi_rd_arbiter;
  logic clk, rst;
  int   errors = 0, checks = 0;
  ddr3_axi_rd_arbiter_if #(.C_ID_WIDTH(2)) bus ();
  ddr3_axi_rd_arbiter dut (.clk(clk), .rst(rst), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  logic [31:0] bad_addr [3] = '{32'hA7FFFFF8, 32'hA4000002, 32'hA3FFFFFC};
  logic [7:0]  bad_len  [3] = '{8'd3, 8'd0, 8'd0};
  initial begin
    int n;
    logic eg;
    rst = 1'b1;
    bus.phy_init_done = 0; bus.req0_valid = 0; bus.req1_valid = 0;
    bus.req0_addr = 0; bus.req1_addr = 0; bus.req0_len = 0; bus.req1_len = 0;
    bus.rd0_ready = 0; bus.rd1_ready = 0; bus.m_axi_arready = 0; bus.m_axi_rid = 0;
    bus.m_axi_rdata = 0; bus.m_axi_rresp = 0; bus.m_axi_rlast = 0; bus.m_axi_rvalid = 0;
    repeat (2) tick;
    chk("rst_busy", bus.busy, 0);
    chk("rst_arvalid", bus.m_axi_arvalid, 0);
    chk("rst_err", bus.err_pulse, 0);
    chk("rst_arsize", bus.m_axi_arsize, 3'b010);
    chk("rst_arburst", bus.m_axi_arburst, 2'b01);
    rst = 1'b0;
    bus.req0_valid = 1; bus.req0_addr = 32'hA4000100; bus.req0_len = 3;
    for (int i = 0; i < 20; i++) begin
      tick;
      chk("init_gate_ready", bus.req0_ready, 0);
      chk("init_gate_arvalid", bus.m_axi_arvalid, 0);
    end
    bus.phy_init_done = 1;
    tick;
    chk("init_grant_ready0", bus.req0_ready, 1);
    chk("init_grant_ready1", bus.req1_ready, 0);
    tick;
    bus.req0_valid = 0;
    chk("single_arvalid", bus.m_axi_arvalid, 1);
    chk("single_araddr", bus.m_axi_araddr, 32'hA4000100);
    chk("single_arlen", bus.m_axi_arlen, 3);
    chk("single_arid", bus.m_axi_arid, 0);
    chk("single_busy", bus.busy, 1);
    tick;
    chk("single_ar_hold", bus.m_axi_arvalid, 1);
    chk("single_ar_hold_addr", bus.m_axi_araddr, 32'hA4000100);
    bus.m_axi_arready = 1;
    tick;
    bus.m_axi_arready = 0;
    chk("single_ar_done", bus.m_axi_arvalid, 0);
    bus.rd0_ready = 1;
    for (int i = 0; i < 4; i++) begin
      bus.m_axi_rvalid = 1; bus.m_axi_rdata = 32'hD0000000 + i; bus.m_axi_rlast = (i == 3);
      #1;
      chk("single_rd0_valid", bus.rd0_valid, 1);
      chk("single_rd0_data", bus.rd0_data, 32'hD0000000 + i);
      chk("single_rd0_last", bus.rd0_last, i == 3);
      chk("single_rd1_valid", bus.rd1_valid, 0);
      chk("single_rready", bus.m_axi_rready, 1);
      tick;
    end
    bus.m_axi_rvalid = 0; bus.m_axi_rlast = 0;
    chk("single_idle", bus.busy, 0);
    // requester 0 went last, so the contest starts with requester 1
    bus.req0_valid = 1; bus.req0_addr = 32'hA4000000; bus.req0_len = 0;
    bus.req1_valid = 1; bus.req1_addr = 32'hA4001000; bus.req1_len = 0;
    bus.rd1_ready = 1;
    for (int k = 0; k < 4; k++) begin
      eg = (k % 2 == 0);
      #1;
      chk("fair_ready1", bus.req1_ready, eg);
      chk("fair_ready0", bus.req0_ready, !eg);
      tick;
      chk("fair_arid", bus.m_axi_arid, eg);
      chk("fair_araddr", bus.m_axi_araddr, eg ? 32'hA4001000 : 32'hA4000000);
      bus.m_axi_arready = 1;
      tick;
      bus.m_axi_arready = 0;
      bus.m_axi_rvalid = 1; bus.m_axi_rlast = 1; bus.m_axi_rdata = k;
      #1;
      chk("fair_granted_valid", eg ? bus.rd1_valid : bus.rd0_valid, 1);
      chk("fair_other_valid", eg ? bus.rd0_valid : bus.rd1_valid, 0);
      tick;
      bus.m_axi_rvalid = 0; bus.m_axi_rlast = 0;
    end
    bus.req0_valid = 0; bus.req1_valid = 0; bus.rd0_ready = 0;
    bus.req1_valid = 1; bus.req1_addr = 32'hA4002000; bus.req1_len = 7;
    #1;
    chk("bp_ready1", bus.req1_ready, 1);
    tick;
    bus.req1_valid = 0;
    chk("bp_arlen", bus.m_axi_arlen, 7);
    bus.m_axi_arready = 1;
    tick;
    bus.m_axi_arready = 0;
    n = 0;
    for (int c = 0; c < 40 && n < 8; c++) begin
      bus.rd1_ready = (c % 2 == 0);
      bus.m_axi_rvalid = 1; bus.m_axi_rdata = 32'hB0 + n; bus.m_axi_rlast = (n == 7);
      #1;
      chk("bp_rready", bus.m_axi_rready, bus.rd1_ready);
      if (bus.rd1_ready) begin
        chk("bp_data", bus.rd1_data, 32'hB0 + n);
        chk("bp_last", bus.rd1_last, n == 7);
      end
      tick;
      if (bus.rd1_ready) n++;
    end
    bus.m_axi_rvalid = 0; bus.m_axi_rlast = 0;
    chk("bp_beats", n, 8);
    chk("bp_idle", bus.busy, 0);
    for (int j = 0; j < 3; j++) begin
      bus.req0_valid = 1; bus.req0_addr = bad_addr[j]; bus.req0_len = bad_len[j];
      #1;
      chk("range_grant", bus.req0_ready, 1);
      tick;
      bus.req0_valid = 0;
      chk("range_err", bus.err_pulse, 1);
      chk("range_no_ar", bus.m_axi_arvalid, 0);
      chk("range_idle", bus.busy, 0);
      tick;
      chk("range_err_clear", bus.err_pulse, 0);
    end
    // last legal burst that ends exactly at the top of the window
    bus.req0_valid = 1; bus.req0_addr = 32'hA7FFFFF0; bus.req0_len = 3;
    #1;
    chk("top_grant", bus.req0_ready, 1);
    tick;
    bus.req0_valid = 0;
    chk("top_arvalid", bus.m_axi_arvalid, 1);
    chk("top_araddr", bus.m_axi_araddr, 32'hA7FFFFF0);
    bus.m_axi_arready = 1;
    tick;
    bus.m_axi_arready = 0;
    bus.rd0_ready = 1; bus.rd1_ready = 0;
    for (int i = 0; i < 3; i++) begin
      bus.m_axi_rvalid = 1; bus.m_axi_rdata = 32'hC0 + i; bus.m_axi_rlast = 0;
      bus.m_axi_rresp = (i == 1) ? 2'b10 : 2'b00;
      #1;
      chk("resp_err", bus.err_pulse, i == 1);
      chk("resp_data", bus.rd0_data, 32'hC0 + i);
      if (i == 2) begin
        rst = 1;
        bus.req0_valid = 1; bus.req0_addr = 32'hA4000000; bus.req0_len = 1;
      end
      tick;
    end
    bus.m_axi_rresp = 0;
    chk("mid_rst_rd0_valid", bus.rd0_valid, 0);
    chk("mid_rst_rready", bus.m_axi_rready, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_err", bus.err_pulse, 0);
    chk("mid_rst_ready_gated", bus.req0_ready, 0);
    bus.m_axi_rvalid = 0;
    rst = 0;
    tick;
    chk("post_rst_grant", bus.req0_ready, 1);
    tick;
    bus.req0_valid = 0;
    bus.m_axi_arready = 1;
    tick;
    bus.m_axi_arready = 0;
    bus.m_axi_rvalid = 1; bus.m_axi_rlast = 1; bus.m_axi_rdata = 32'hE0;
    #1;
    chk("early_last_err", bus.err_pulse, 1);
    chk("early_last_rd0_last", bus.rd0_last, 1);
    tick;
    bus.m_axi_rvalid = 0; bus.m_axi_rlast = 0;
    chk("early_last_idle", bus.busy, 0);
    bus.req0_valid = 1; bus.req0_addr = 32'hA4000010; bus.req0_len = 0;
    #1;
    chk("cnt0_grant", bus.req0_ready, 1);
    tick;
    bus.req0_valid = 0;
    bus.m_axi_arready = 1;
    tick;
    bus.m_axi_arready = 0;
    bus.m_axi_rvalid = 1; bus.m_axi_rlast = 0; bus.m_axi_rdata = 32'hF0;
    #1;
    chk("cnt0_forced_last", bus.rd0_last, 1);
    chk("cnt0_err", bus.err_pulse, 1);
    tick;
    bus.m_axi_rvalid = 0;
    chk("cnt0_idle", bus.busy, 0);
    chk("cnt0_err_clear", bus.err_pulse, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
